// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, FSM state and port-index types for mem_port_arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  // 0 = CPU port, 1 = DMA/host port
  typedef logic port_t;

endpackage

// File: rtl/mem_arb_pick2.sv
// rtl/mem_arb_pick2.sv - two-way request picker; MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module mem_arb_pick2
  import mem_arb_pkg::*;
(
  input  logic  req0,
  input  logic  req1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  port_t last_gnt,
`endif
  output logic  pick_valid,
  output port_t pick
);

  // Choose a winner; only a tie depends on the policy.
  always_comb begin
    pick_valid = req0 | req1;
    pick       = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick = ~last_gnt;
`else
      pick = 1'b0;
`endif
    end else if (req1) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port req/gnt controller for a 64x32 RAM with registered read address (MEM_ARB_ROUND_ROBIN_EN: round-robin ties)
module mem_port_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              mem_clk,
  input  logic              mem_rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mc_address_mem,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mc_busy
);

  import mem_arb_pkg::*;

  state_e            state_q, state_d;
  port_t             cur_port_q, cur_port_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  port_t             pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_t             last_gnt_q, last_gnt_d;
`endif

  mem_arb_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_gnt   (last_gnt_q),
`endif
    .pick_valid (pick_valid),
    .pick       (pick)
  );

  // Next-state and next-output logic; address/data hold between accesses, pulses default low.
  always_comb begin
    state_d    = state_q;
    cur_port_d = cur_port_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    din_d      = din_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_gnt_d = last_gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          cur_port_d = pick;
          if (pick == 1'b1) begin
            gnt1_d = 1'b1;
            addr_d = addr1;
            din_d  = wdata1;
            we_d   = we1;
          end else begin
            gnt0_d = 1'b1;
            addr_d = addr0;
            din_d  = wdata0;
            we_d   = we0;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_gnt_d = pick;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // RAM acts on this edge; a write is complete, a read needs one more cycle for data.
        state_d = we_q ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (cur_port_q == 1'b1) begin
          rdata1_d  = mem_data_out;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_data_out;
          rvalid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q    <= IDLE;
      cur_port_q <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cur_port_q <= cur_port_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  assign gnt0           = gnt0_q;
  assign gnt1           = gnt1_q;
  assign rvalid0        = rvalid0_q;
  assign rvalid1        = rvalid1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mc_address_mem = addr_q;
  assign mem_we         = we_q;
  assign mem_data_in    = din_q;
  assign mc_busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with RAM model and transaction-level reference
module tb_mem_port_arbiter;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
  } acc_t;

  logic        clk, rst_n;
  logic        req0, req1, we0, we1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, mc_busy;
  logic [31:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [5:0]  mc_address_mem;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mem_port_arbiter dut (
    .mem_clk(clk), .mem_rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mc_address_mem(mc_address_mem), .mem_we(mem_we), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mc_busy(mc_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM macro: write on edge, address registered, new-data read
  logic [31:0] ram [64];
  logic [5:0]  ram_addr_q;
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram_addr_q = 6'd0;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mc_address_mem] <= mem_data_in;
    ram_addr_q <= mc_address_mem;
  end
  assign mem_data_out = ram[ram_addr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requesters: hold req until gnt seen, drop in the gnt cycle, then take the next queued access
  acc_t q0[$];
  acc_t q1[$];

  initial begin
    req0 = 1'b0; we0 = 1'b0; addr0 = 6'd0; wdata0 = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        req0 = 1'b0; q0.delete();
      end else if (req0 && gnt0) begin
        req0 = 1'b0; q0.delete(0);
      end else if (!req0 && q0.size() > 0) begin
        req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
      end
    end
  end

  initial begin
    req1 = 1'b0; we1 = 1'b0; addr1 = 6'd0; wdata1 = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        req1 = 1'b0; q1.delete();
      end else if (req1 && gnt1) begin
        req1 = 1'b0; q1.delete(0);
      end else if (!req1 && q1.size() > 0) begin
        req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
      end
    end
  end

  // Reference: an access occupies 2 (write) or 3 (read) edges counted from its grant edge
  logic [31:0] mem_model [64];
  logic        exp_gnt0, exp_gnt1, exp_rv0, exp_rv1, exp_we, exp_busy;
  logic [31:0] exp_rdata0, exp_rdata1, exp_din;
  logic [5:0]  exp_addr;
  int          rem;
  logic        last_m, cur_port, cur_we, p;
  logic [5:0]  cur_addr;
  logic [31:0] cur_data;

  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
    rem = 0; last_m = 1'b1; cur_port = 1'b0; cur_we = 1'b0; cur_addr = 6'd0; cur_data = 32'h0;
    exp_gnt0 = 0; exp_gnt1 = 0; exp_rv0 = 0; exp_rv1 = 0; exp_we = 0; exp_busy = 0;
    exp_rdata0 = 0; exp_rdata1 = 0; exp_din = 0; exp_addr = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        rem = 0; last_m = 1'b1;
        exp_gnt0 = 0; exp_gnt1 = 0; exp_rv0 = 0; exp_rv1 = 0; exp_we = 0; exp_busy = 0;
        exp_rdata0 = 0; exp_rdata1 = 0; exp_din = 0; exp_addr = 0;
      end else begin
        exp_gnt0 = 0; exp_gnt1 = 0; exp_rv0 = 0; exp_rv1 = 0; exp_we = 0;
        if (rem > 0) begin
          rem = rem - 1;
          if (rem == 0) begin
            if (cur_we) mem_model[cur_addr] = cur_data;
            else if (cur_port) begin exp_rv1 = 1; exp_rdata1 = mem_model[cur_addr]; end
            else begin exp_rv0 = 1; exp_rdata0 = mem_model[cur_addr]; end
          end
        end else if (req0 || req1) begin
          if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            p = ~last_m;
`else
            p = 1'b0;
`endif
          end else begin
            p = req1;
          end
          cur_port = p;
          cur_we   = p ? we1 : we0;
          cur_addr = p ? addr1 : addr0;
          cur_data = p ? wdata1 : wdata0;
          exp_addr = cur_addr; exp_din = cur_data; exp_we = cur_we;
          if (p) exp_gnt1 = 1; else exp_gnt0 = 1;
          last_m = p;
          rem = cur_we ? 1 : 2;
        end
        exp_busy = (rem > 0);
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the reference
  initial forever begin
    @(negedge clk);
    chk("gnt0", gnt0, exp_gnt0);
    chk("gnt1", gnt1, exp_gnt1);
    chk("rvalid0", rvalid0, exp_rv0);
    chk("rvalid1", rvalid1, exp_rv1);
    chk("rdata0", rdata0, exp_rdata0);
    chk("rdata1", rdata1, exp_rdata1);
    chk("mc_address_mem", mc_address_mem, exp_addr);
    chk("mem_we", mem_we, exp_we);
    chk("mem_data_in", mem_data_in, exp_din);
    chk("mc_busy", mc_busy, exp_busy);
  end

  // Event logs for the directed literal checks
  int          gl_cyc[$];
  int          gl_port[$];
  int          rv0_cyc[$];
  int          rv1_cyc[$];
  logic [31:0] rv0_data[$];
  logic [31:0] rv1_data[$];
  int          we_cnt;

  initial begin
    we_cnt = 0;
    forever begin
      @(negedge clk);
      if (gnt0) begin gl_cyc.push_back(cyc); gl_port.push_back(0); end
      if (gnt1) begin gl_cyc.push_back(cyc); gl_port.push_back(1); end
      if (rvalid0) begin rv0_cyc.push_back(cyc); rv0_data.push_back(rdata0); end
      if (rvalid1) begin rv1_cyc.push_back(cyc); rv1_data.push_back(rdata1); end
      if (mem_we) we_cnt++;
    end
  end

  task automatic clear_logs();
    gl_cyc.delete(); gl_port.delete(); rv0_cyc.delete(); rv1_cyc.delete();
    rv0_data.delete(); rv1_data.delete(); we_cnt = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0 || req1 || mc_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 300), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_gnt0(input string name);
    int n = 0;
    while (!gnt0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, gnt0, 1'b1);
  endtask

  function automatic acc_t mk(input logic we, input logic [5:0] a, input logic [31:0] d);
    acc_t x;
    x.we = we; x.addr = a; x.data = d;
    return x;
  endfunction

  function automatic acc_t rand_acc();
    return mk(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom);
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
    chk("rst_we", mem_we, 0); chk("rst_busy", mc_busy, 0);
    chk("rst_addr", mc_address_mem, 0); chk("rst_rdata0", rdata0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Port 0 write then read of address 5
    clear_logs();
    q0.push_back(mk(1'b1, 6'd5, 32'hDEADBEEF));
    wait_idle("t2_write_idle");
    q0.push_back(mk(1'b0, 6'd5, 32'h0));
    wait_idle("t2_read_idle");
    chk("t2_gnt_count", gl_cyc.size(), 2);
    chk("t2_we_cycles", we_cnt, 1);
    chk("t2_rvalid_count", rv0_cyc.size(), 1);
    chk("t2_rvalid_latency", rv0_cyc[0] - gl_cyc[1], 2);
    chk("t2_rdata0", rv0_data[0], 32'hDEADBEEF);

    // Preload addresses 1 and 2 for the tie test
    q0.push_back(mk(1'b1, 6'd1, 32'h11111111));
    q1.push_back(mk(1'b1, 6'd2, 32'h22222222));
    wait_idle("preload_idle");

    // Reset while a read sits in ISSUE
    clear_logs();
    q0.push_back(mk(1'b0, 6'd5, 32'h0));
    wait_gnt0("t1_gnt0_seen");
    #1 rst_n = 1'b0;
    #1;
    chk("t1_gnt0_zero", gnt0, 0); chk("t1_busy_zero", mc_busy, 0);
    chk("t1_we_zero", mem_we, 0); chk("t1_addr_zero", mc_address_mem, 0);
    chk("t1_din_zero", mem_data_in, 0); chk("t1_rdata0_zero", rdata0, 0);
    chk("t1_rdata1_zero", rdata1, 0); chk("t1_rvalid0_zero", rvalid0, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_no_rvalid", rv0_cyc.size(), 0);
    chk("t1_idle_busy", mc_busy, 0);

    // Tie: both ports read continuously, two reads each
    clear_logs();
    q0.push_back(mk(1'b0, 6'd1, 32'h0)); q0.push_back(mk(1'b0, 6'd1, 32'h0));
    q1.push_back(mk(1'b0, 6'd2, 32'h0)); q1.push_back(mk(1'b0, 6'd2, 32'h0));
    wait_idle("t3_idle");
    chk("t3_gnt_count", gl_port.size(), 4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("t3_order0", gl_port[0], 0); chk("t3_order1", gl_port[1], 1);
    chk("t3_order2", gl_port[2], 0); chk("t3_order3", gl_port[3], 1);
`else
    chk("t3_order0", gl_port[0], 0); chk("t3_order1", gl_port[1], 0);
    chk("t3_order2", gl_port[2], 1); chk("t3_order3", gl_port[3], 1);
`endif
    chk("t3_rdata0", rdata0, 32'h11111111);
    chk("t3_rdata1", rdata1, 32'h22222222);

    // Port 1 back-to-back writes to 63 and 0, then read both
    clear_logs();
    q1.push_back(mk(1'b1, 6'd63, 32'd1)); q1.push_back(mk(1'b1, 6'd0, 32'd2));
    q1.push_back(mk(1'b0, 6'd63, 32'd0)); q1.push_back(mk(1'b0, 6'd0, 32'd0));
    wait_idle("t5_idle");
    chk("t5_gnt_count", gl_cyc.size(), 4);
    chk("t5_spacing_ww", gl_cyc[1] - gl_cyc[0], 2);
    chk("t5_spacing_wr", gl_cyc[2] - gl_cyc[1], 2);
    chk("t5_spacing_rr", gl_cyc[3] - gl_cyc[2], 3);
    chk("t5_read63", rv1_data[0], 32'd1);
    chk("t5_read0", rv1_data[1], 32'd2);
    chk("t5_we_cycles", we_cnt, 2);

    // req1 rises while port 0's read is in CAPTURE
    clear_logs();
    q0.push_back(mk(1'b0, 6'd5, 32'h0));
    wait_gnt0("t6_gnt0_seen");
    q1.push_back(mk(1'b1, 6'd10, 32'hA5A5A5A5));
    @(negedge clk);
    chk("t6_req1_in_capture", req1, 1);
    chk("t6_busy_in_capture", mc_busy, 1);
    chk("t6_no_gnt1_yet", gnt1, 0);
    wait_idle("t6_idle");
    chk("t6_gnt1_port", gl_port[1], 1);
    chk("t6_gnt1_delay", gl_cyc[1] - gl_cyc[0], 3);
    chk("t6_rdata0", rdata0, 32'hDEADBEEF);

    // Random traffic with one asynchronous reset pulse mid-cycle
    clear_logs();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_acc());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_acc());
      if (i == 150) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    wait_idle("rand_idle");
    chk("rand_grants_seen", (gl_cyc.size() > 20), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
